spi_word_writer: RTL and testbench

- SPI slave that receives pixel words from the host MCU and writes them into the output driver's 16-bit word memory.
- Sits directly upstream of the ICND2110 output stage and drives its spi_data / spi_address / spi_write_strobe write port.
- Frame format: one 16-bit start-address header, then any number of 16-bit data words written to auto-incrementing addresses.

---
 rtl/spi_word_writer.sv | 176 +++++++++++++++++
 tb/tb_spi_word_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_writer.sv
// spi_word_writer: SPI mode-0 slave that turns a framed word stream
// (one start-address header, then data words) into single-cycle writes
// on the output driver's word-memory port, with auto-incrementing
// addresses and a per-frame completion pulse.
module spi_word_writer #(
  parameter int WORD_COUNT        = 336,
  parameter int ADDRESS_BUS_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_sck,
  input  logic                         spi_cs_n,
  input  logic                         spi_mosi,
  output logic [15:0]                  spi_data,
  output logic [ADDRESS_BUS_WIDTH:0]   spi_address,
  output logic                         spi_write_strobe,
  output logic                         frame_done
);

  localparam int DATA_W = 16;
  localparam int AW     = ADDRESS_BUS_WIDTH + 1;
  localparam logic [AW-1:0] WC_A = AW'(WORD_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  // Synchroniser stages: _p0/_p1 form the two-flop synchroniser, _p2 is the
  // previous synced sample used for edge detection.
  logic r_sck_p0, r_sck_p1, r_sck_p2;
  logic r_cs_p0,  r_cs_p1,  r_cs_p2;
  logic r_mosi_p0, r_mosi_p1;

  state_t              r_state;
  logic [3:0]          r_bit_cnt;
  logic [DATA_W-2:0]   r_shift;
  logic [AW-1:0]       r_addr;
  logic                r_written;
  logic                r_close;
  logic [DATA_W-1:0]   r_data;
  logic [AW-1:0]       r_out_addr;
  logic                r_strobe;
  logic                r_frame_done;

  logic                w_sck_rise;
  logic                w_cs_rise;
  logic                w_cs_fall;
  logic                w_last_bit;
  logic [DATA_W-1:0]   w_word;
  logic [AW-1:0]       w_addr_inc;

  // Bring the asynchronous SPI pins into the clk domain. The chain is left
  // free-running through reset so that a chip select still held low after a
  // reset is not mistaken for a fresh falling edge.
  always_ff @(posedge clk) begin
    r_sck_p0  <= spi_sck;
    r_sck_p1  <= r_sck_p0;
    r_sck_p2  <= r_sck_p1;
    r_cs_p0   <= spi_cs_n;
    r_cs_p1   <= r_cs_p0;
    r_cs_p2   <= r_cs_p1;
    r_mosi_p0 <= spi_mosi;
    r_mosi_p1 <= r_mosi_p0;
  end

  assign w_sck_rise = r_sck_p1 & ~r_sck_p2;
  assign w_cs_rise  = r_cs_p1  & ~r_cs_p2;
  assign w_cs_fall  = ~r_cs_p1 &  r_cs_p2;
  assign w_last_bit = w_sck_rise && (r_bit_cnt == 4'd15);
  assign w_word     = {r_shift, r_mosi_p1};
  assign w_addr_inc = r_addr + 1'b1;

  // Frame FSM: header/data deserialisation, address tracking and the
  // registered write-port / frame-completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 4'd0;
      r_addr       <= '0;
      r_written    <= 1'b0;
      r_close      <= 1'b0;
      r_data       <= '0;
      r_out_addr   <= '0;
      r_strobe     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_strobe     <= 1'b0;
      r_frame_done <= 1'b0;
      r_close      <= 1'b0;

      // Completion is reported one cycle after the frame closes so that a
      // word finishing on the same cycle as the cs_n rise strobes first.
      if (r_close) begin
        r_frame_done <= r_written;
        r_written    <= 1'b0;
      end

      if (w_cs_rise) begin
        if ((r_state == DATA) && w_last_bit) begin
          r_strobe   <= 1'b1;
          r_data     <= w_word;
          r_out_addr <= r_addr;
          r_addr     <= w_addr_inc;
          r_written  <= 1'b1;
        end
        r_state   <= IDLE;
        r_bit_cnt <= 4'd0;
        r_close   <= 1'b1;
      end else if (w_cs_fall) begin
        // Also taken outside IDLE: a missed cs_n rise restarts the header.
        r_state   <= HEADER;
        r_bit_cnt <= 4'd0;
        r_shift   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_bit_cnt <= 4'd0;
          end

          HEADER: begin
            if (w_sck_rise) begin
              r_shift   <= w_word[DATA_W-2:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_last_bit) begin
                r_bit_cnt <= 4'd0;
                r_addr    <= w_word[ADDRESS_BUS_WIDTH:0];
                if (int'(w_word) >= WORD_COUNT) begin
                  r_state <= DISCARD;
                end else begin
                  r_state <= DATA;
                end
              end
            end
          end

          DATA: begin
            if (w_sck_rise) begin
              r_shift   <= w_word[DATA_W-2:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_last_bit) begin
                r_bit_cnt  <= 4'd0;
                r_strobe   <= 1'b1;
                r_data     <= w_word;
                r_out_addr <= r_addr;
                r_addr     <= w_addr_inc;
                r_written  <= 1'b1;
                // No wrap-around: the rest of the frame is dropped once the
                // top of memory has been written.
                if (w_addr_inc == WC_A) begin
                  r_state <= DISCARD;
                end
              end
            end
          end

          DISCARD: begin
            r_bit_cnt <= 4'd0;
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign spi_data         = r_data;
  assign spi_address      = r_out_addr;
  assign spi_write_strobe = r_strobe;
  assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_spi_word_writer.sv
// Directed bench for spi_word_writer: drives SPI frames bit by bit and
// checks the write strobes and frame_done pulses that come out.
module tb_spi_word_writer;

  localparam int WC  = 336;
  localparam int ABW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_sck;
  logic          spi_cs_n;
  logic          spi_mosi;
  logic [15:0]   spi_data;
  logic [ABW:0]  spi_address;
  logic          spi_write_strobe;
  logic          frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  int n_stb = 0;
  int n_fd  = 0;
  logic [15:0]  cap_d [0:63];
  logic [ABW:0] cap_a [0:63];

  spi_word_writer #(.WORD_COUNT(WC), .ADDRESS_BUS_WIDTH(ABW)) dut (
    .clk              (clk),
    .rst              (rst),
    .spi_sck          (spi_sck),
    .spi_cs_n         (spi_cs_n),
    .spi_mosi         (spi_mosi),
    .spi_data         (spi_data),
    .spi_address      (spi_address),
    .spi_write_strobe (spi_write_strobe),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  // Log every strobe and frame_done cycle, sampled away from the active edge.
  always @(negedge clk) begin
    if (spi_write_strobe === 1'b1) begin
      if (n_stb < 64) begin
        cap_d[n_stb] = spi_data;
        cap_a[n_stb] = spi_address;
      end
      n_stb = n_stb + 1;
    end
    if (frame_done === 1'b1) n_fd = n_fd + 1;
  end

  // sck half period of 50 ns = 5 clk, i.e. sck = clk/10.
  task automatic send_bits(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      spi_mosi = w[i];
      #50;
      spi_sck = 1'b1;
      #50;
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #200;
  endtask

  task automatic cs_high();
    #50;
    spi_cs_n = 1'b1;
    #300;
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (spi_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", spi_data); end
    n_cmp++;
    if (spi_address !== 13'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", spi_address); end
    n_cmp++;
    if (spi_write_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got=%b exp=0", spi_write_strobe); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", frame_done); end
  endtask

  task automatic test_basic_frame();
    int s0, f0;
    s0 = n_stb; f0 = n_fd;
    cs_low();
    send_bits(16'h0005, 16);
    send_bits(16'h1234, 16);
    send_bits(16'hABCD, 16);
    cs_high();
    n_cmp++;
    if (n_stb - s0 !== 2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", n_stb - s0); end
    n_cmp++;
    if (cap_a[s0] !== 13'd5 || cap_d[s0] !== 16'h1234) begin n_fail++;
      $display("FAIL basic_w0 got=%0d/%h exp=5/1234", cap_a[s0], cap_d[s0]); end
    n_cmp++;
    if (cap_a[s0+1] !== 13'd6 || cap_d[s0+1] !== 16'hABCD) begin n_fail++;
      $display("FAIL basic_w1 got=%0d/%h exp=6/abcd", cap_a[s0+1], cap_d[s0+1]); end
    n_cmp++;
    if (n_fd - f0 !== 1) begin n_fail++; $display("FAIL basic_done got=%0d exp=1", n_fd - f0); end
    n_cmp++;
    if (spi_data !== 16'hABCD || spi_address !== 13'd6) begin n_fail++;
      $display("FAIL basic_hold got=%h/%0d exp=abcd/6", spi_data, spi_address); end
  endtask

  task automatic test_top_of_memory();
    int s0, f0;
    s0 = n_stb; f0 = n_fd;
    cs_low();
    send_bits(16'h014E, 16);
    send_bits(16'h1111, 16);
    send_bits(16'h2222, 16);
    send_bits(16'h3333, 16);
    cs_high();
    n_cmp++;
    if (n_stb - s0 !== 2) begin n_fail++; $display("FAIL top_count got=%0d exp=2", n_stb - s0); end
    n_cmp++;
    if (cap_a[s0] !== 13'd334 || cap_d[s0] !== 16'h1111) begin n_fail++;
      $display("FAIL top_w0 got=%0d/%h exp=334/1111", cap_a[s0], cap_d[s0]); end
    n_cmp++;
    if (cap_a[s0+1] !== 13'd335 || cap_d[s0+1] !== 16'h2222) begin n_fail++;
      $display("FAIL top_w1 got=%0d/%h exp=335/2222", cap_a[s0+1], cap_d[s0+1]); end
    n_cmp++;
    if (n_fd - f0 !== 1) begin n_fail++; $display("FAIL top_done got=%0d exp=1", n_fd - f0); end
  endtask

  task automatic test_bad_header();
    int s0, f0;
    s0 = n_stb; f0 = n_fd;
    cs_low();
    send_bits(16'h0150, 16);
    send_bits(16'hFFFF, 16);
    cs_high();
    n_cmp++;
    if (n_stb - s0 !== 0) begin n_fail++; $display("FAIL badhdr_count got=%0d exp=0", n_stb - s0); end
    n_cmp++;
    if (n_fd - f0 !== 0) begin n_fail++; $display("FAIL badhdr_done got=%0d exp=0", n_fd - f0); end
  endtask

  task automatic test_partial_word();
    int s0, f0;
    s0 = n_stb; f0 = n_fd;
    cs_low();
    send_bits(16'h0000, 16);
    send_bits(16'hBEEF, 16);
    send_bits(16'hFE00, 7);
    cs_high();
    n_cmp++;
    if (n_stb - s0 !== 1) begin n_fail++; $display("FAIL partial_count got=%0d exp=1", n_stb - s0); end
    n_cmp++;
    if (cap_a[s0] !== 13'd0 || cap_d[s0] !== 16'hBEEF) begin n_fail++;
      $display("FAIL partial_w0 got=%0d/%h exp=0/beef", cap_a[s0], cap_d[s0]); end
    n_cmp++;
    if (n_fd - f0 !== 1) begin n_fail++; $display("FAIL partial_done got=%0d exp=1", n_fd - f0); end
  endtask

  task automatic test_mid_frame_reset();
    int s0, f0;
    s0 = n_stb; f0 = n_fd;
    cs_low();
    send_bits(16'h0007, 16);
    send_bits(16'h5555, 10);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (spi_data !== 16'h0000) begin n_fail++; $display("FAIL rst_data got=%h exp=0000", spi_data); end
    cs_high();
    n_cmp++;
    if (n_stb - s0 !== 0 || n_fd - f0 !== 0) begin n_fail++;
      $display("FAIL rst_aborted got=%0d strobes %0d done exp=0/0", n_stb - s0, n_fd - f0); end
    s0 = n_stb; f0 = n_fd;
    cs_low();
    send_bits(16'h0002, 16);
    send_bits(16'h00AA, 16);
    cs_high();
    n_cmp++;
    if (n_stb - s0 !== 1) begin n_fail++; $display("FAIL rst_count got=%0d exp=1", n_stb - s0); end
    n_cmp++;
    if (cap_a[s0] !== 13'd2 || cap_d[s0] !== 16'h00AA) begin n_fail++;
      $display("FAIL rst_w0 got=%0d/%h exp=2/00aa", cap_a[s0], cap_d[s0]); end
    n_cmp++;
    if (n_fd - f0 !== 1) begin n_fail++; $display("FAIL rst_done got=%0d exp=1", n_fd - f0); end
  endtask

  task automatic test_idle_sck();
    int s0, f0;
    s0 = n_stb; f0 = n_fd;
    for (int i = 0; i < 100; i++) begin
      spi_mosi = i[1];
      #40;
      spi_sck = ~spi_sck;
    end
    spi_sck = 1'b0;
    #200;
    n_cmp++;
    if (n_stb - s0 !== 0) begin n_fail++; $display("FAIL idle_count got=%0d exp=0", n_stb - s0); end
    n_cmp++;
    if (n_fd - f0 !== 0) begin n_fail++; $display("FAIL idle_done got=%0d exp=0", n_fd - f0); end
    n_cmp++;
    if (spi_data !== 16'h00AA || spi_address !== 13'd2) begin n_fail++;
      $display("FAIL idle_hold got=%h/%0d exp=00aa/2", spi_data, spi_address); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_top_of_memory();
    test_bad_header();
    test_partial_word();
    test_mid_frame_reset();
    test_idle_sck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
